// File: rtl/vproc_mac_pipe.sv
// Elastic signed multiply-accumulate pipeline: res = {0,acc} +/- op1*op2 (mod 2^RES_W).
// Each of the three optional register stages has its own valid bit and a bubble-collapsing enable.
module vproc_mac_pipe #(
  parameter int unsigned OP_W    = 17,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned RES_W   = 33,
  parameter int unsigned TAG_W   = 4,
  parameter bit          BUF_OPS = 1'b1,
  parameter bit          BUF_MUL = 1'b1,
  parameter bit          BUF_RES = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [OP_W-1:0]  op1_i,
  input  logic [OP_W-1:0]  op2_i,
  input  logic [ACC_W-1:0] acc_i,
  input  logic             acc_flag_i,
  input  logic             acc_sub_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [RES_W-1:0] res_o,
  output logic [TAG_W-1:0] tag_o
);

  // The product is only needed modulo 2^RES_W, so operands are widened to RES_W and multiplied there.
  function automatic logic [RES_W-1:0] sext_op(input logic [OP_W-1:0] v);
    return {{(RES_W-OP_W){v[OP_W-1]}}, v};
  endfunction

  function automatic logic [RES_W-1:0] zext_acc(input logic [ACC_W-1:0] v);
    return {{(RES_W-ACC_W){1'b0}}, v};
  endfunction

  logic [ACC_W-1:0] in_acc_s;

  logic             s1_valid_s;
  logic             s1_ready_s;
  logic [OP_W-1:0]  s1_op1_s;
  logic [OP_W-1:0]  s1_op2_s;
  logic [ACC_W-1:0] s1_acc_s;
  logic             s1_sub_s;
  logic [TAG_W-1:0] s1_tag_s;

  logic [RES_W-1:0] prod_s;

  logic             s2_valid_s;
  logic             s2_ready_s;
  logic [RES_W-1:0] s2_prod_s;
  logic [ACC_W-1:0] s2_acc_s;
  logic             s2_sub_s;
  logic [TAG_W-1:0] s2_tag_s;

  logic [RES_W-1:0] sum_s;

  // The accumulate flag is folded into the accumulator value at acceptance.
  assign in_acc_s = acc_flag_i ? acc_i : {ACC_W{1'b0}};

  generate
    if (BUF_OPS) begin : g_ops
      logic             v_r;
      logic [OP_W-1:0]  op1_r;
      logic [OP_W-1:0]  op2_r;
      logic [ACC_W-1:0] acc_r;
      logic             sub_r;
      logic [TAG_W-1:0] tag_r;

      assign ready_o = !v_r || s1_ready_s;

      // Operand stage: loads whenever its slot is empty or drains downstream.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_r   <= 1'b0;
          op1_r <= {OP_W{1'b0}};
          op2_r <= {OP_W{1'b0}};
          acc_r <= {ACC_W{1'b0}};
          sub_r <= 1'b0;
          tag_r <= {TAG_W{1'b0}};
        end else if (ready_o) begin
          v_r   <= valid_i;
          op1_r <= op1_i;
          op2_r <= op2_i;
          acc_r <= in_acc_s;
          sub_r <= acc_sub_i;
          tag_r <= tag_i;
        end
      end

      assign s1_valid_s = v_r;
      assign s1_op1_s   = op1_r;
      assign s1_op2_s   = op2_r;
      assign s1_acc_s   = acc_r;
      assign s1_sub_s   = sub_r;
      assign s1_tag_s   = tag_r;
    end else begin : g_ops_byp
      assign ready_o    = s1_ready_s;
      assign s1_valid_s = valid_i;
      assign s1_op1_s   = op1_i;
      assign s1_op2_s   = op2_i;
      assign s1_acc_s   = in_acc_s;
      assign s1_sub_s   = acc_sub_i;
      assign s1_tag_s   = tag_i;
    end
  endgenerate

  assign prod_s = sext_op(s1_op1_s) * sext_op(s1_op2_s);

  generate
    if (BUF_MUL) begin : g_mul
      logic             v_r;
      logic [RES_W-1:0] prod_r;
      logic [ACC_W-1:0] acc_r;
      logic             sub_r;
      logic [TAG_W-1:0] tag_r;

      assign s1_ready_s = !v_r || s2_ready_s;

      // Product stage.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_r    <= 1'b0;
          prod_r <= {RES_W{1'b0}};
          acc_r  <= {ACC_W{1'b0}};
          sub_r  <= 1'b0;
          tag_r  <= {TAG_W{1'b0}};
        end else if (s1_ready_s) begin
          v_r    <= s1_valid_s;
          prod_r <= prod_s;
          acc_r  <= s1_acc_s;
          sub_r  <= s1_sub_s;
          tag_r  <= s1_tag_s;
        end
      end

      assign s2_valid_s = v_r;
      assign s2_prod_s  = prod_r;
      assign s2_acc_s   = acc_r;
      assign s2_sub_s   = sub_r;
      assign s2_tag_s   = tag_r;
    end else begin : g_mul_byp
      assign s1_ready_s = s2_ready_s;
      assign s2_valid_s = s1_valid_s;
      assign s2_prod_s  = prod_s;
      assign s2_acc_s   = s1_acc_s;
      assign s2_sub_s   = s1_sub_s;
      assign s2_tag_s   = s1_tag_s;
    end
  endgenerate

  assign sum_s = s2_sub_s ? (zext_acc(s2_acc_s) - s2_prod_s)
                          : (zext_acc(s2_acc_s) + s2_prod_s);

  generate
    if (BUF_RES) begin : g_res
      logic             v_r;
      logic [RES_W-1:0] res_r;
      logic [TAG_W-1:0] tag_r;

      assign s2_ready_s = !v_r || ready_i;

      // Result stage: holds its content while the consumer stalls.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_r   <= 1'b0;
          res_r <= {RES_W{1'b0}};
          tag_r <= {TAG_W{1'b0}};
        end else if (s2_ready_s) begin
          v_r   <= s2_valid_s;
          res_r <= sum_s;
          tag_r <= s2_tag_s;
        end
      end

      assign valid_o = v_r;
      assign res_o   = res_r;
      assign tag_o   = tag_r;
    end else begin : g_res_byp
      assign s2_ready_s = ready_i;
      assign valid_o    = s2_valid_s;
      assign res_o      = sum_s;
      assign tag_o      = s2_tag_s;
    end
  endgenerate

endmodule

// File: tb/tb_vproc_mac_pipe.sv
// Self-checking bench: four stage configurations share one random stream and are
// scored against a plain-arithmetic model with per-instance in-order scoreboards.
module tb_vproc_mac_pipe;

  localparam int NI = 4;
  localparam bit [2:0] CFG [NI] = '{3'b111, 3'b000, 3'b011, 3'b101};

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [16:0] op1;
  logic [16:0] op2;
  logic [15:0] acc;
  logic        acc_flag;
  logic        acc_sub;
  logic [3:0]  tag;

  logic [NI-1:0]       rdy_w;
  logic [NI-1:0]       vld_w;
  logic [NI-1:0][32:0] res_w;
  logic [NI-1:0][3:0]  tag_w;

  int n_chk;
  int n_pass;
  int cyc;

  logic [36:0] sb [NI][16];
  int          wp [NI];
  int          rp [NI];
  int          out_cnt [NI];
  logic        hold_pend [NI];
  logic [32:0] hold_res [NI];
  logic [3:0]  hold_tag [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      vproc_mac_pipe #(
        .OP_W(17), .ACC_W(16), .RES_W(33), .TAG_W(4),
        .BUF_OPS(CFG[g][2]), .BUF_MUL(CFG[g][1]), .BUF_RES(CFG[g][0])
      ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(rdy_w[g]),
        .op1_i(op1), .op2_i(op2), .acc_i(acc), .acc_flag_i(acc_flag),
        .acc_sub_i(acc_sub), .tag_i(tag), .valid_o(vld_w[g]), .ready_i(ready_in),
        .res_o(res_w[g]), .tag_o(tag_w[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
  endtask

  function automatic int lat_of(input int k);
    return int'(CFG[k][2]) + int'(CFG[k][1]) + int'(CFG[k][0]);
  endfunction

  function automatic logic [32:0] ref_mac(input logic [16:0] a, input logic [16:0] b,
                                          input logic [15:0] c, input logic fl, input logic sb_);
    longint p, av, r;
    p  = longint'($signed(a)) * longint'($signed(b));
    av = fl ? longint'(c) : 64'sd0;
    r  = sb_ ? av - p : av + p;
    return r[32:0];
  endfunction

  task automatic flush();
    for (int k = 0; k < NI; k++) begin
      rp[k] = wp[k];
      hold_pend[k] = 1'b0;
    end
  endtask

  task automatic monitor();
    logic [36:0] e;
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        if (valid_in && rdy_w[k]) begin
          sb[k][wp[k] % 16] = {tag, ref_mac(op1, op2, acc, acc_flag, acc_sub)};
          wp[k]++;
        end
        if (lat_of(k) > 0 && hold_pend[k]) begin
          chk($sformatf("hold_valid%0d", k), 64'(vld_w[k]), 64'd1);
          chk($sformatf("hold_res%0d", k), 64'(res_w[k]), 64'(hold_res[k]));
          chk($sformatf("hold_tag%0d", k), 64'(tag_w[k]), 64'(hold_tag[k]));
        end
        hold_pend[k] = vld_w[k] && !ready_in;
        hold_res[k]  = res_w[k];
        hold_tag[k]  = tag_w[k];
        if (vld_w[k] && ready_in) begin
          chk($sformatf("spurious%0d", k), 64'(wp[k] != rp[k]), 64'd1);
          if (wp[k] != rp[k]) begin
            e = sb[k][rp[k] % 16];
            rp[k]++;
            chk($sformatf("res%0d", k), 64'(res_w[k]), 64'(e[32:0]));
            chk($sformatf("tag%0d", k), 64'(tag_w[k]), 64'(e[36:33]));
          end
          out_cnt[k]++;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [16:0] a, input logic [16:0] b,
                       input logic [15:0] c, input logic fl, input logic s,
                       input logic [3:0] t, input logic r);
    valid_in = v; op1 = a; op2 = b; acc = c; acc_flag = fl; acc_sub = s; tag = t; ready_in = r;
  endtask

  // One operation into an empty pipeline; checks value, tag and latency on instance 0.
  task automatic run_one(input string name, input logic [16:0] a, input logic [16:0] b,
                         input logic [15:0] c, input logic fl, input logic s,
                         input logic [3:0] t, input logic [32:0] exp);
    logic found;
    found = 1'b0;
    drive(1'b1, a, b, c, fl, s, t, 1'b1);
    #1;
    chk({name, "_ready"}, 64'(rdy_w[0]), 64'd1);
    tick();
    drive(1'b0, 17'd0, 17'd0, 16'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      if (!found) begin
        #1;
        if (vld_w[0]) begin
          found = 1'b1;
          chk({name, "_res"}, 64'(res_w[0]), 64'(exp));
          chk({name, "_tag"}, 64'(tag_w[0]), 64'(t));
          chk({name, "_lat"}, 64'(j + 1), 64'd3);
        end
        tick();
      end
    end
    chk({name, "_timeout"}, 64'(found), 64'd1);
  endtask

  initial begin
    int next_tag, base, i;
    logic seen [NI];
    n_chk = 0; n_pass = 0; cyc = 0;
    for (int k = 0; k < NI; k++) begin
      wp[k] = 0; rp[k] = 0; out_cnt[k] = 0; hold_pend[k] = 1'b0;
    end
    rst_n = 1'b0;
    drive(1'b0, 17'd0, 17'd0, 16'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(vld_w[0]), 64'd0);
    chk("rst_res", 64'(res_w[0]), 64'd0);
    chk("rst_tag", 64'(tag_w[0]), 64'd0);
    chk("rst_ready", 64'(rdy_w[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic cases.
    run_one("t1", 17'd3, 17'h1FFFE, 16'd10, 1'b1, 1'b0, 4'hA, 33'd4);
    run_one("t2a", 17'd3, 17'd4, 16'd5, 1'b1, 1'b1, 4'h3, 33'h1_FFFF_FFF9);
    run_one("t2b", 17'd3, 17'd4, 16'd5, 1'b0, 1'b1, 4'h5, 33'h1_FFFF_FFF4);
    run_one("t3a", 17'h10000, 17'h10000, 16'h1234, 1'b0, 1'b0, 4'h7, 33'h1_0000_0000);
    run_one("t3b", 17'h1FFFF, 17'h1FFFF, 16'hFFFF, 1'b1, 1'b0, 4'h9, 33'h0_0001_0000);

    // Back-pressure: tags 0..7, ready_i low on cycles 4..9.
    next_tag = 0;
    base = out_cnt[0];
    i = 0;
    while (out_cnt[0] - base < 8 && i < 60) begin
      drive(next_tag < 8, 17'($urandom), 17'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom), 4'(next_tag), !(i >= 4 && i <= 9));
      #1;
      if (i == 9) chk("t4_ready_full", 64'(rdy_w[0]), 64'd0);
      if (valid_in && rdy_w[0]) next_tag++;
      tick();
      i++;
    end
    chk("t4_count", 64'(out_cnt[0] - base), 64'd8);

    // Reset with three operations in flight.
    drive(1'b0, 17'd0, 17'd0, 16'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    repeat (4) tick();
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 17'($urandom), 17'($urandom), 16'($urandom), 1'b1, 1'b0, 4'(j + 1), 1'b1);
      tick();
    end
    drive(1'b0, 17'd0, 17'd0, 16'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("t5_inflight", 64'(vld_w[0]), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(vld_w[0]), 64'd0);
    chk("t5_res", 64'(res_w[0]), 64'd0);
    chk("t5_tag", 64'(tag_w[0]), 64'd0);
    flush();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    flush();
    base = out_cnt[0];
    ready_in = 1'b1;
    repeat (6) tick();
    chk("t5_no_stale", 64'(out_cnt[0] - base), 64'd0);

    // Latency probe on every configuration.
    for (int k = 0; k < NI; k++) seen[k] = 1'b0;
    drive(1'b1, 17'd7, 17'd9, 16'd1, 1'b1, 1'b0, 4'hC, 1'b1);
    for (int j = 0; j < 6; j++) begin
      #1;
      for (int k = 0; k < NI; k++) begin
        if (!seen[k] && vld_w[k]) begin
          seen[k] = 1'b1;
          chk($sformatf("lat%0d", k), 64'(j), 64'(lat_of(k)));
        end
      end
      tick();
      valid_in = 1'b0;
    end
    for (int k = 0; k < NI; k++) chk($sformatf("lat_seen%0d", k), 64'(seen[k]), 64'd1);

    // Random stream with random back-pressure across all configurations.
    for (int n = 0; n < 12000; n++) begin
      logic [16:0] a, b;
      a = 17'($urandom);
      b = 17'($urandom);
      if ($urandom_range(0, 9) == 0) a = 17'h10000;
      if ($urandom_range(0, 9) == 0) b = 17'h1FFFF;
      drive($urandom_range(0, 9) < 7, a, b, 16'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom), $urandom_range(0, 9) < 7);
      tick();
    end
    drive(1'b0, 17'd0, 17'd0, 16'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    repeat (8) tick();
    for (int k = 0; k < NI; k++) chk($sformatf("drain%0d", k), 64'(wp[k] - rp[k]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
